muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Sequencer for RV32M multiply/divide ops issued from EX.
- Owns the iterative restoring divider and a registered multiplier.
- Accepts one op at a time with a start/done handshake.
- Drives the pipeline division stall (hazard_t.division) until the result is ready in EX.

Parameters:
- XLEN, 32, operand/result width; must be even and ≥ 8.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  op request, sampled each edge.
- flush  input  1  kill in-flight op (branch mispredict/trap).
- alu_op  input  5  alu_op_e; only ALU_MUL..ALU_REMU are accepted.
- operand_a  input  XLEN  rs1 value / dividend.
- operand_b  input  XLEN  rs2 value / divisor.
- busy  output  1  op in flight (state not IDLE).
- done  output  1  one-cycle pulse; result valid this cycle.
- result  output  XLEN  op result, held until the next accepted start.
- div_stall  output  1  stall request to the hazard unit.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, div_stall=0, result=0.
  - All internal registers (quotient, remainder, divisor, counter, sign flags) cleared.
- States: IDLE, MUL, PREP, ITER, DONE. Cycle 0 is the cycle in which start is sampled.
- Accept rule:
  - start=1, flush=0, alu_op[4]=1, state in {IDLE, DONE} → op accepted.
  - Operands and op are latched at the edge ending cycle 0.
  - start with a non-M alu_op is ignored: no state change, no done.
  - start while state is MUL, PREP or ITER is ignored; the bench flags it as a protocol error.
- MUL path (ALU_MUL/MULH/MULHSU/MULHU):
  - 2·XLEN product per signedness: MULH s×s, MULHSU s×u, MULHU u×u.
  - MUL returns the low XLEN bits; the high variants return the high XLEN bits.
  - IDLE→MUL; MUL→DONE. done=1 in cycle 2.
- DIV path, PREP cycle (cycle 1):
  - Take magnitudes for signed ops (DIV, REM); record quotient sign (a^b) and remainder sign (a).
  - Check special cases.
- DIV path, special cases (PREP→DONE, done in cycle 2):
  - Divisor=0: DIV/DIVU return all ones; REM/REMU return operand_a.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF) for DIV/REM: DIV returns 0x80000000, REM returns 0.
- DIV path, iteration:
  - ITER runs exactly XLEN cycles (counter 0..XLEN-1), one restoring step per cycle.
  - ITER→DONE after the last step; done=1 in cycle XLEN+2 (cycle 34 for XLEN=32).
  - Result sign-corrected in the DONE cycle.
- DONE state:
  - done=1, result valid.
  - Next state is IDLE, or PREP/MUL if a new start is accepted in that cycle (back-to-back ops allowed).
- div_stall:
  - = (accept condition in IDLE) OR state in {MUL, PREP, ITER}, combinational.
  - Low in the DONE cycle so EX advances and captures result.
- busy = state != IDLE.
- flush=1:
  - Next state IDLE, done suppressed, result unchanged, div_stall dropped combinationally that cycle.
  - flush and start in the same cycle: flush wins, nothing accepted.
- Reset asserted mid-operation: immediate return to reset values; no done pulse afterwards.
- Widths: counter $clog2(XLEN)+1 bits; remainder register XLEN+1 bits for the subtract.

Optional Feature:
- Macro: MULDIV_EARLY_EXIT_EN.
- Defined: in PREP, if |a| < |b| (magnitudes, unsigned compare) and b≠0 → PREP→DONE, done in cycle 2.
  - Quotient=0; remainder=operand_a (original signed value).
- Undefined: every non-special divide takes the full XLEN+2 cycles.

Test Plan:
- Reset then idle → busy=0, done=0, div_stall=0, result=0.
- MUL 0x00010000×0x00010000 → done in cycle 2. MUL result 0; MULHU result 0x00000001. MULH 0xFFFFFFFF×0xFFFFFFFF → 0.
- DIV 100/-7 → done in cycle 34, result 0xFFFFFFF2 (-14). REM 100/-7 → 2. div_stall high cycles 0–33, low in cycle 34.
- DIVU 5/0 → 0xFFFFFFFF, done in cycle 2. REM 0x80000000/0xFFFFFFFF → 0. DIV of the same operands → 0x80000000.
- DIVU 1000/3 started, flush in cycle 10 → no done, busy=0 in cycle 11, result unchanged. New DIVU 9/2 issued in cycle 11 → result 4 in cycle 45.
- MULDIV_EARLY_EXIT_EN: REMU 3/10 → result 3, done in cycle 2. Macro undefined: done in cycle 34.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: RV32M multiply/divide sequencer with a registered multiplier and a restoring divider.
// Latency: MUL ops and divide special cases pulse done in cycle 2, other divides in cycle XLEN+2.
// Backpressure: one op at a time; starts while busy are ignored; div_stall holds EX until done.
// Optional macro MULDIV_EARLY_EXIT_EN: divides with |a| < |b| finish from PREP in cycle 2.
module muldiv_seq #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            flush,
   input  logic [4:0]      alu_op,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic            div_stall
);

   localparam int              CW       = $clog2(XLEN) + 1;
   localparam logic [CW-1:0]   LAST_CNT = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_MUL, S_PREP, S_ITER, S_DONE} state_t;

   state_t          r_state;
   state_t          w_next;

   // r_quot doubles as operand A / product / quotient, r_div as operand B / divisor
   logic [2:0]      r_op;
   logic [XLEN-1:0] r_quot;
   logic [XLEN-1:0] r_div;
   logic [XLEN:0]   r_rem;
   logic [CW-1:0]   r_cnt;
   logic            r_qsign;
   logic            r_rsign;
   logic            r_sel_rem;
   logic [XLEN-1:0] r_result;

   logic              w_accept;
   logic              w_is_div;
   logic              w_mul_a_sgn;
   logic              w_mul_b_sgn;
   logic [2*XLEN-1:0] w_mul_a;
   logic [2*XLEN-1:0] w_mul_b;
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0]   w_mul_res;
   logic              w_div_sgn;
   logic              w_is_rem;
   logic              w_a_neg;
   logic              w_b_neg;
   logic [XLEN-1:0]   w_mag_a;
   logic [XLEN-1:0]   w_mag_b;
   logic              w_div_zero;
   logic              w_ovf;
   logic              w_special;
   logic [XLEN-1:0]   w_special_val;
   logic              w_early;
   logic [XLEN:0]     w_rem_sh;
   logic [XLEN:0]     w_diff;
   logic              w_fits;
   logic [XLEN:0]     w_step_rem;
   logic [XLEN-1:0]   w_step_quot;
   logic [XLEN-1:0]   w_q_fin;
   logic [XLEN-1:0]   w_r_fin;
   logic [XLEN-1:0]   w_final;
   logic [1:0]        w_unused;

   // Only the M-extension ops (alu_op[4] set) start work, and only when not mid-op.
   assign w_accept = start & ~flush & alu_op[4] & ((r_state == S_IDLE) | (r_state == S_DONE));
   assign w_is_div = alu_op[2];

   // Multiplier: sign-extend per op to 2*XLEN so one unsigned multiply covers all variants.
   assign w_mul_a_sgn = (r_op[1:0] == 2'd1) | (r_op[1:0] == 2'd2);
   assign w_mul_b_sgn = (r_op[1:0] == 2'd1);
   assign w_mul_a     = {{XLEN{w_mul_a_sgn & r_quot[XLEN-1]}}, r_quot};
   assign w_mul_b     = {{XLEN{w_mul_b_sgn & r_div[XLEN-1]}}, r_div};
   assign w_prod      = w_mul_a * w_mul_b;
   assign w_mul_res   = (r_op[1:0] == 2'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

   // Divide preparation: op[0]=0 means signed (DIV/REM), op[1]=1 means remainder wanted.
   assign w_div_sgn  = ~r_op[0];
   assign w_is_rem   = r_op[1];
   assign w_a_neg    = w_div_sgn & r_quot[XLEN-1];
   assign w_b_neg    = w_div_sgn & r_div[XLEN-1];
   assign w_mag_a    = w_a_neg ? -r_quot : r_quot;
   assign w_mag_b    = w_b_neg ? -r_div : r_div;
   assign w_div_zero = (r_div == '0);
   assign w_ovf      = w_div_sgn & (r_quot == MIN_NEG) & (r_div == '1);
   assign w_special  = w_div_zero | w_ovf;
   // Divide-by-zero gives all ones / dividend; signed overflow gives MIN_NEG / zero.
   assign w_special_val = w_div_zero ? (w_is_rem ? r_quot : '1)
                                     : (w_is_rem ? '0 : MIN_NEG);

`ifdef MULDIV_EARLY_EXIT_EN
   assign w_early = ~w_div_zero & (w_mag_a < w_mag_b);
`else
   assign w_early = 1'b0;
`endif

   // One restoring step: shift the next dividend bit in, subtract, keep if non-negative.
   assign w_rem_sh    = {r_rem[XLEN-1:0], r_quot[XLEN-1]};
   assign w_diff      = w_rem_sh - {1'b0, r_div};
   assign w_fits      = ~w_diff[XLEN];
   assign w_step_rem  = w_fits ? w_diff : w_rem_sh;
   assign w_step_quot = {r_quot[XLEN-2:0], w_fits};

   // Sign correction applied while in DONE; MUL and special results carry clear sign flags.
   assign w_q_fin = r_qsign ? -r_quot : r_quot;
   assign w_r_fin = r_rsign ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];
   assign w_final = r_sel_rem ? w_r_fin : w_q_fin;

   // alu_op[3] does not affect decode; the remainder top bit only absorbs the subtract borrow.
   assign w_unused = {alu_op[3], r_rem[XLEN]};

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic; flush overrides everything, including a same-cycle start.
   always_comb begin
      w_next = S_IDLE;
      if (!flush) begin
         case (r_state)
            S_IDLE:  w_next = w_accept ? (w_is_div ? S_PREP : S_MUL) : S_IDLE;
            S_MUL:   w_next = S_DONE;
            S_PREP:  w_next = (w_special | w_early) ? S_DONE : S_ITER;
            S_ITER:  w_next = (r_cnt == LAST_CNT) ? S_DONE : S_ITER;
            S_DONE:  w_next = w_accept ? (w_is_div ? S_PREP : S_MUL) : S_IDLE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   // Control outputs; div_stall drops in DONE so EX can capture the result.
   always_comb begin
      busy      = (r_state != S_IDLE);
      done      = (r_state == S_DONE) & ~flush;
      div_stall = ~flush & (((r_state == S_IDLE) & w_accept) | (r_state == S_MUL) |
                            (r_state == S_PREP) | (r_state == S_ITER));
   end

   // Datapath: latch operands on accept, then multiply, prepare or iterate per state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op      <= '0;
         r_quot    <= '0;
         r_div     <= '0;
         r_rem     <= '0;
         r_cnt     <= '0;
         r_qsign   <= 1'b0;
         r_rsign   <= 1'b0;
         r_sel_rem <= 1'b0;
      end else if (w_accept) begin
         r_op      <= alu_op[2:0];
         r_quot    <= operand_a;
         r_div     <= operand_b;
         r_rem     <= '0;
         r_cnt     <= '0;
         r_qsign   <= 1'b0;
         r_rsign   <= 1'b0;
         r_sel_rem <= 1'b0;
      end else begin
         case (r_state)
            S_MUL: begin
               r_quot <= w_mul_res;
            end
            S_PREP: begin
               if (w_special) begin
                  r_quot <= w_special_val;
               end else if (w_early) begin
                  // Quotient is zero and the remainder is the dividend exactly as given.
                  r_rem     <= {1'b0, r_quot};
                  r_quot    <= '0;
                  r_sel_rem <= w_is_rem;
               end else begin
                  r_quot    <= w_mag_a;
                  r_div     <= w_mag_b;
                  r_rem     <= '0;
                  r_cnt     <= '0;
                  r_qsign   <= w_a_neg ^ w_b_neg;
                  r_rsign   <= w_a_neg;
                  r_sel_rem <= w_is_rem;
               end
            end
            S_ITER: begin
               r_rem  <= w_step_rem;
               r_quot <= w_step_quot;
               r_cnt  <= r_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Result holding register, refreshed when DONE completes without a flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              r_result <= '0;
      else if ((r_state == S_DONE) && !flush)  r_result <= w_final;
   end

   assign result = ((r_state == S_DONE) && !flush) ? w_final : r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed plus randomized checks of muldiv_seq against an arithmetic reference.
// Every cycle compares busy/done/div_stall and result against a per-op timeline model.
// Cycle k runs posedge to posedge; inputs are driven 1 time unit after posedge, outputs sampled at negedge.
module tb_muldiv_seq;

   localparam logic [4:0] MUL    = 5'h10;
   localparam logic [4:0] MULH   = 5'h11;
   localparam logic [4:0] MULHSU = 5'h12;
   localparam logic [4:0] MULHU  = 5'h13;
   localparam logic [4:0] DIV    = 5'h14;
   localparam logic [4:0] DIVU   = 5'h15;
   localparam logic [4:0] REM    = 5'h16;
   localparam logic [4:0] REMU   = 5'h17;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        flush;
   logic [4:0]  alu_op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        div_stall;

   muldiv_seq #(.XLEN(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .flush     (flush),
      .alu_op    (alu_op),
      .operand_a (a),
      .operand_b (b),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .div_stall (div_stall)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Timeline model of the op in flight.
   int          cyc;
   bit          act;
   int          iss_c;
   int          done_c;
   int          flush_c;
   int          b2b_c;
   int          last_done_c;
   logic [31:0] cur_res;
   logic [31:0] held_res;
   logic [31:0] b2b_res;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // RV32M reference: plain arithmetic plus the architectural special cases.
   function automatic void model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] r, output int lat);
      logic [63:0] p;
      longint      sx;
      longint      sy;
      longint      ux;
      longint      uy;
      int          xi;
      int          yi;
      longint      mx;
      longint      my;
      bit          ovf;
      sx  = longint'($signed(x));
      sy  = longint'($signed(y));
      ux  = longint'({32'd0, x});
      uy  = longint'({32'd0, y});
      xi  = x;
      yi  = y;
      ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
      lat = 2;
      r   = '0;
      p   = '0;
      case (op)
         3'd0: begin p = {32'd0, x} * {32'd0, y}; r = p[31:0];  end
         3'd1: begin p = sx * sy;                 r = p[63:32]; end
         3'd2: begin p = sx * uy;                 r = p[63:32]; end
         3'd3: begin p = {32'd0, x} * {32'd0, y}; r = p[63:32]; end
         3'd4: begin
            if (y == 0) r = 32'hFFFF_FFFF;
            else if (ovf) r = x;
            else begin r = xi / yi; lat = 34; end
         end
         3'd5: begin
            if (y == 0) r = 32'hFFFF_FFFF;
            else begin r = x / y; lat = 34; end
         end
         3'd6: begin
            if (y == 0) r = x;
            else if (ovf) r = 32'd0;
            else begin r = xi % yi; lat = 34; end
         end
         default: begin
            if (y == 0) r = x;
            else begin r = x % y; lat = 34; end
         end
      endcase
`ifdef MULDIV_EARLY_EXIT_EN
      if (op[2] && y != 0 && !(ovf && !op[0])) begin
         mx = op[0] ? ux : ((sx < 0) ? -sx : sx);
         my = op[0] ? uy : ((sy < 0) ? -sy : sy);
         if (mx < my) lat = 2;
      end
`else
      mx = ux;
      my = uy;
      if (mx < 0 || my < 0) lat = 0;
`endif
   endfunction

   task automatic issue(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
      logic [31:0] r;
      int          l;
      model(op[2:0], x, y, r, l);
      if (act && cyc == done_c) begin
         b2b_c   = cyc;
         b2b_res = cur_res;
      end
      act     = 1'b1;
      iss_c   = cyc;
      done_c  = cyc + l;
      cur_res = r;
      start   = 1'b1;
      alu_op  = op;
      a       = x;
      b       = y;
   endtask

   // Check the current cycle against the timeline, then advance to the next cycle.
   task automatic tick();
      bit          fl;
      bit          e_done;
      bit          e_busy;
      bit          e_stall;
      logic [31:0] e_res;
      @(negedge clk);
      fl = (cyc == flush_c);
      if (cyc == b2b_c) begin
         e_done  = 1'b1;
         e_busy  = 1'b1;
         e_stall = 1'b0;
         e_res   = b2b_res;
      end else begin
         e_done  = act && (cyc == done_c) && !fl;
         e_busy  = act && (cyc > iss_c) && (cyc <= done_c);
         e_stall = act && (cyc >= iss_c) && (cyc < done_c) && !fl;
         e_res   = e_done ? cur_res : held_res;
      end
      n_total++;
      assert ({busy, done, div_stall} === {e_busy, e_done, e_stall}) n_pass++;
      else $error("FAIL ctl cyc=%0d busy/done/stall observed=%b expected=%b",
                  cyc, {busy, done, div_stall}, {e_busy, e_done, e_stall});
      chk($sformatf("result_cyc%0d", cyc), result, e_res);
      if (done === 1'b1) last_done_c = cyc;
      if (e_done) held_res = e_res;
      if (fl || (act && cyc >= done_c)) act = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      start = 1'b0;
      flush = 1'b0;
   endtask

   // Run one op from idle to completion and compare against stated constants.
   task automatic run_k(input string tag, input logic [4:0] op, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] k_res, input int k_lat);
      int ic;
      int ec;
      last_done_c = -1000;
      issue(op, x, y);
      ic = iss_c;
      ec = done_c;
      while (cyc <= ec) tick();
      chk({tag, "_res"}, result, k_res);
      chk({tag, "_lat"}, 32'(last_done_c - ic), 32'(k_lat));
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   task automatic rnd_issue();
      logic [4:0]  op;
      logic [31:0] x;
      logic [31:0] y;
      op = 5'h10 | 5'($urandom_range(0, 7));
      x  = pick();
      y  = pick();
      issue(op, x, y);
   endtask

   int end_c;
   int ic0;
   int early_lat;

   initial begin
      rst_n = 1'b0; start = 1'b0; flush = 1'b0; alu_op = '0; a = '0; b = '0;
      cyc = 0; act = 1'b0; iss_c = 0; done_c = 0; flush_c = -1; b2b_c = -1;
      last_done_c = -1000; cur_res = '0; held_res = '0; b2b_res = '0;
`ifdef MULDIV_EARLY_EXIT_EN
      early_lat = 2;
`else
      early_lat = 34;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_stall", 32'(div_stall), 32'd0);
      chk("rst_result", result, 32'd0);
      rst_n = 1'b1;
      tick();

      run_k("mul", MUL, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 2);
      run_k("mulhu", MULHU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 2);
      run_k("mulh_m1", MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2);
      run_k("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 2);
      run_k("div_neg", DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 34);
      run_k("rem_neg", REM, 32'd100, 32'hFFFF_FFF9, 32'd2, 34);
      run_k("divu_zero", DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
      run_k("remu_zero", REMU, 32'd5, 32'd0, 32'd5, 2);
      run_k("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);
      run_k("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
      run_k("remu_small", REMU, 32'd3, 32'd10, 32'd3, early_lat);
      run_k("rem_negdvd", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);

      // Flush mid-divide in cycle 10, then a fresh divide in cycle 11.
      issue(DIVU, 32'd1000, 32'd3);
      ic0 = iss_c;
      repeat (10) tick();
      flush   = 1'b1;
      flush_c = cyc;
      tick();
      chk("flush_busy", 32'(busy), 32'd0);
      chk("flush_hold", result, held_res);
      run_k("divu_after_flush", DIVU, 32'd9, 32'd2, 32'd4, 34);
      chk("flush_total_lat", 32'(last_done_c - ic0), 32'd45);

      // Back-to-back: a divide accepted in the MUL op's DONE cycle.
      issue(MUL, 32'd7, 32'd6);
      tick();
      tick();
      issue(DIVU, 32'd50, 32'd7);
      tick();
      end_c = done_c;
      while (cyc <= end_c) tick();
      chk("b2b_res", result, 32'd7);

      // Non-M start is ignored; start together with flush is ignored.
      start = 1'b1; alu_op = 5'h05; a = 32'd1; b = 32'd1;
      tick();
      start = 1'b1; flush = 1'b1; alu_op = DIV; flush_c = cyc;
      tick();
      tick();

      // Randomized ops, some issued back-to-back in the previous op's DONE cycle.
      rnd_issue();
      for (int i = 0; i < 40; i++) begin
         end_c = done_c;
         while (cyc < end_c) tick();
         if (i < 39 && $urandom_range(0, 1) == 1) begin
            rnd_issue();
            tick();
         end else begin
            tick();
            if (i < 39) begin
               repeat ($urandom_range(0, 2)) tick();
               rnd_issue();
            end
         end
      end
      tick();

      // Reset in the middle of a divide: immediate reset values and no later done.
      issue(DIV, 32'd100, 32'd7);
      repeat (5) tick();
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_stall", 32'(div_stall), 32'd0);
      chk("mid_rst_result", result, 32'd0);
      act = 1'b0; held_res = '0; b2b_c = -1;
      #1 rst_n = 1'b1;
      repeat (40) tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
